clk_div_monitor: RTL
====================

// Module: clk_div_monitor
// PURPOSE
//  Measures the period and high time of a divided clock produced from i_ref_clk by the clock divider.
//  Counts i_ref_clk cycles between rising edges of the sampled i_div_clk, reports the measured ratio,
//  and flags lock, mismatch against an expected ratio, and loss of toggling.
//  Used as the on-chip checker placed at the divider output.
// PARAMETERS
//  MAX_DIV_BITS  4  width of ratio/expected-ratio fields; max measurable period = 2**MAX_DIV_BITS-1
//  SYNC_STAGES   2  input sampling flops before edge detection (0..2)
//  LOCK_CNT      3  consecutive equal periods required to assert o_locked (>=2)
// PORTS
//  i_ref_clk     in   1             the single clock; all logic on its rising edge
//  i_rst         in   1             reset, synchronous and active-high
//  i_en          in   1             monitor enable; low = hold in IDLE
//  i_div_clk     in   1             divided clock under test, sampled as data
//  i_exp_ratio   in   MAX_DIV_BITS  expected division ratio
//  o_ratio       out  MAX_DIV_BITS  last measured period in i_ref_clk cycles
//  o_high_cnt    out  MAX_DIV_BITS  sampled-high cycles within that period
//  o_valid       out  1             1-cycle pulse when o_ratio/o_high_cnt update
//  o_locked      out  1             LOCK_CNT consecutive identical periods seen
//  o_mismatch    out  1             o_locked && o_ratio != i_exp_ratio
//  o_timeout     out  1             no rising edge within 2**MAX_DIV_BITS-1 cycles
// BEHAVIOUR
//  One clock; reset is synchronous and active-high.
//  - Reset or i_en=0: all outputs 0, counters 0, sync flops 0, state=IDLE. Reset wins over i_en.
//  - Sampling: i_div_clk passes SYNC_STAGES flops to s, plus one flop s_q. Edge strobe rise = s & ~s_q.
//    Rise asserts SYNC_STAGES+1 cycles after the input transition is sampled.
//  - FSM: IDLE -> (i_en) SYNC -> (rise) MEAS; MEAS -> (rise) MEAS; MEAS/SYNC -> (timeout) SYNC.
//  - In SYNC: wait for the first rise; cnt<=1 and hcnt<=s on that rise; no o_valid.
//  - In MEAS, each cycle without rise: cnt<=cnt+1, hcnt<=hcnt+s.
//  - In MEAS on rise: o_ratio<=cnt, o_high_cnt<=hcnt, o_valid=1 the next cycle;
//    then cnt<=1 and hcnt<=s (the rise cycle counts as cycle 1 of the new period, s=1).
//  - Counter width is MAX_DIV_BITS+1 internally; no wrap.
//  - Timeout: when cnt reaches 2**MAX_DIV_BITS-1 without rise (in SYNC, a wait counter does the same):
//    o_timeout<=1, o_locked<=0, o_mismatch<=0, go to SYNC, no o_valid.
//    o_timeout stays high until the next o_valid.
//  - Lock: match counter increments on each o_valid with ratio equal to previous o_ratio, else resets to 1.
//    o_locked=1 when the count reaches LOCK_CNT; it clears in the same cycle as an o_valid with a
//    differing ratio (the new ratio is then count 1).
//  - o_mismatch: registered; recomputed on every o_valid and also whenever i_exp_ratio changes while locked.
//  - Ratio-1 / passthrough or a stuck input gives no rise, which is reported only via o_timeout.
//  - i_en falling mid-period: the partial period is discarded; re-enable restarts in SYNC.
//  - Rise coincident with timeout threshold: rise wins (valid period = threshold value).
// TESTING
//  1 Bench drives i_div_clk high 2 / low 2 ref cycles, i_exp_ratio=4 -> o_valid every 4 cycles;
//    o_ratio=4, o_high_cnt=2; o_locked on 3rd o_valid; o_mismatch=0.
//  2 Pattern high 2 / low 3, i_exp_ratio=4 -> o_ratio=5, o_high_cnt=2, o_locked after 3 periods,
//    then o_mismatch=1.
//  3 Locked at ratio 4, switch pattern to 3/3 -> first o_valid shows 6 with o_locked=0;
//    re-lock on the 3rd ratio-6 o_valid.
//  4 Hold i_div_clk=0 after lock -> o_timeout=1 and o_locked=0 exactly 15 cycles after last cnt reset;
//    resume 2/2 -> o_timeout clears on next o_valid.
//  5 i_rst=1 for one cycle mid-period -> next cycle all outputs 0;
//    first o_valid only after a full period following the first new rise.
//  6 i_en=0 for 5 cycles while locked -> outputs 0 during low; re-enable -> SYNC, no o_valid from the partial period.

Source files
------------

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: on-chip checker for a clock divider output.
// Samples the divided clock as data in the i_ref_clk domain, measures the
// period and high time between successive rising edges, and reports lock,
// mismatch against an expected ratio, and loss of toggling.
module clk_div_monitor #(
    parameter int MAX_DIV_BITS = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int LOCK_CNT     = 3
) (
    input  logic                    i_ref_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic                    i_div_clk,
    input  logic [MAX_DIV_BITS-1:0] i_exp_ratio,
    output logic [MAX_DIV_BITS-1:0] o_ratio,
    output logic [MAX_DIV_BITS-1:0] o_high_cnt,
    output logic                    o_valid,
    output logic                    o_locked,
    output logic                    o_mismatch,
    output logic                    o_timeout
);

    localparam int W  = MAX_DIV_BITS;
    localparam int CW = MAX_DIV_BITS + 1;
    localparam int MW = $clog2(LOCK_CNT + 1);

    // Longest period we can measure; reaching it without an edge is a timeout.
    localparam logic [CW-1:0] THRESH   = CW'((2 ** MAX_DIV_BITS) - 1);
    localparam logic [MW-1:0] LOCK_VAL = MW'(LOCK_CNT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_MEAS = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;

    logic           w_s;
    logic           r_s_q;
    logic           w_rise;

    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_hcnt;
    logic [W-1:0]   r_ratio;
    logic [W-1:0]   r_high;
    logic           r_valid;
    logic [MW-1:0]  r_match;
    logic           r_locked;
    logic           r_mismatch;
    logic           r_timeout;

    logic           w_start;
    logic           w_period;
    logic           w_timeout;
    logic           w_advance;
    logic [MW-1:0]  w_match_next;
    logic           w_lock_next;

    // Input sampling chain; disable clears it so a re-enable never sees a stale edge.
    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;

            // Shift i_div_clk through SYNC_STAGES sampling flops.
            always_ff @(posedge i_ref_clk) begin
                // NOTE: sequential state always uses non-blocking assignments so every
                // flop samples pre-edge values regardless of statement order.
                if (i_rst || !i_en) begin
                    r_sync <= '0;
                end else begin
                    r_sync[0] <= i_div_clk;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end

            assign w_s = r_sync[SYNC_STAGES-1];
        end else begin : g_nosync
            assign w_s = i_div_clk;
        end
    endgenerate

    // Delayed copy of the sampled level for rising-edge detection.
    always_ff @(posedge i_ref_clk) begin
        if (i_rst || !i_en) begin
            r_s_q <= 1'b0;
        end else begin
            r_s_q <= w_s;
        end
    end

    assign w_rise = w_s & ~r_s_q;

    // FSM state register.
    always_ff @(posedge i_ref_clk) begin
        if (i_rst || !i_en) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        // NOTE: defaulting every combinational output first keeps any missed
        // branch from inferring a latch.
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: if (i_en) w_state_next = ST_SYNC;
            ST_SYNC: if (w_rise) w_state_next = ST_MEAS;
            ST_MEAS: if (!w_rise && (r_cnt == THRESH)) w_state_next = ST_SYNC;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FSM output decode: per-cycle measurement events and the next lock count.
    always_comb begin
        w_start      = (r_state == ST_SYNC) && w_rise;
        w_period     = (r_state == ST_MEAS) && w_rise;
        // A rise on the threshold cycle wins, so timeout needs the absence of rise.
        w_timeout    = (r_state != ST_IDLE) && !w_rise && (r_cnt == THRESH);
        w_advance    = (r_state != ST_IDLE) && !w_rise && (r_cnt != THRESH);
        w_match_next = MW'(1);
        if ((r_match != '0) && (r_cnt[W-1:0] == r_ratio)) begin
            w_match_next = (r_match == LOCK_VAL) ? r_match : r_match + 1'b1;
        end
        w_lock_next  = (w_match_next == LOCK_VAL);
    end

    // Period/high-time counters; the rise cycle is cycle 1 of the new period.
    always_ff @(posedge i_ref_clk) begin
        if (i_rst || !i_en) begin
            r_cnt  <= '0;
            r_hcnt <= '0;
        end else if (w_start || w_period) begin
            r_cnt  <= CW'(1);
            r_hcnt <= W'(w_s);
        end else if (w_timeout) begin
            r_cnt  <= '0;
            r_hcnt <= '0;
        end else if (w_advance) begin
            r_cnt  <= r_cnt + 1'b1;
            r_hcnt <= r_hcnt + W'(w_s);
        end
    end

    // Result, lock, mismatch and timeout reporting.
    always_ff @(posedge i_ref_clk) begin
        if (i_rst || !i_en) begin
            r_ratio    <= '0;
            r_high     <= '0;
            r_valid    <= 1'b0;
            r_match    <= '0;
            r_locked   <= 1'b0;
            r_mismatch <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_valid <= w_period;
            if (w_period) begin
                r_ratio    <= r_cnt[W-1:0];
                r_high     <= r_hcnt;
                r_match    <= w_match_next;
                r_locked   <= w_lock_next;
                r_mismatch <= w_lock_next && (r_cnt[W-1:0] != i_exp_ratio);
                r_timeout  <= 1'b0;
            end else if (w_timeout) begin
                // Loss of toggling breaks the run of identical periods.
                r_match    <= '0;
                r_locked   <= 1'b0;
                r_mismatch <= 1'b0;
                r_timeout  <= 1'b1;
            end else begin
                // Tracks i_exp_ratio changes while locked.
                r_mismatch <= r_locked && (r_ratio != i_exp_ratio);
            end
        end
    end

    assign o_ratio    = r_ratio;
    assign o_high_cnt = r_high;
    assign o_valid    = r_valid;
    assign o_locked   = r_locked;
    assign o_mismatch = r_mismatch;
    assign o_timeout  = r_timeout;

endmodule
